// File: rtl/rom_loader.sv
// Packs an 8-bit ROM download stream into 16-bit SDRAM word writes with byte enables,
// backpressure, a one-entry skid register and a flush of the last half word.
module rom_loader #(
   parameter logic [26:0] BASE_ADDR = 27'h0,
   parameter bit          BYTE_SWAP = 1'b0
) (
   input  logic        clk,
   input  logic        init,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [26:1] sdr_addr,
   output logic [15:0] sdr_din,
   output logic [1:0]  sdr_be,
   output logic        sdr_rnw,
   output logic        sdr_req,
   input  logic        sdr_ready,
   output logic        done,
   output logic [25:0] wr_count
);
   localparam int unsigned WAW = 26;
   localparam logic [WAW-1:0] BASE_WORD = BASE_ADDR[26:1];

   typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;

   state_t         state;
   logic           pend;
   logic [WAW-1:0] pend_waddr;
   logic [7:0]     pend_data;
   logic           skid_full;
   logic [WAW-1:0] skid_waddr;
   logic           skid_odd;
   logic [7:0]     skid_data;
   logic           overflow;
   logic           dl_q;
   logic           ending;

   // Even byte lands in the low lane unless BYTE_SWAP moves it to the high lane.
   function automatic logic [15:0] pack(input logic [7:0] even_b, input logic [7:0] odd_b);
      return BYTE_SWAP ? {even_b, odd_b} : {odd_b, even_b};
   endfunction

   // Byte to process in IDLE: the skidded one always goes first.
   logic           live_c;
   logic [WAW-1:0] live_waddr_c;
   logic [WAW-1:0] in_waddr_c;
   logic           in_odd_c;
   logic [7:0]     in_data_c;
   logic           in_valid_c;
   logic           mismatch_c;
   logic           idle_c;
   logic           drop_c;
   logic           load_skid_c;
   logic           dl_rise_c;
   logic           dl_fall_c;

   assign live_c       = ioctl_wr & ioctl_download;
   assign live_waddr_c = ioctl_addr[26:1] + BASE_WORD;
   assign in_waddr_c   = skid_full ? skid_waddr : live_waddr_c;
   assign in_odd_c     = skid_full ? skid_odd : ioctl_addr[0];
   assign in_data_c    = skid_full ? skid_data : ioctl_dout;
   assign in_valid_c   = skid_full | live_c;
   assign mismatch_c   = pend & (in_waddr_c != pend_waddr);
   assign idle_c       = (state == IDLE);
   assign drop_c       = live_c & skid_full & (~idle_c | mismatch_c);
   assign load_skid_c  = live_c & ~drop_c & (~idle_c | skid_full | mismatch_c);
   assign dl_rise_c    = ioctl_download & ~dl_q;
   assign dl_fall_c    = ~ioctl_download & dl_q;

   assign ioctl_wait = ~idle_c | skid_full;
   assign sdr_rnw    = 1'b0;

   always_ff @(posedge clk) begin
      if (init) begin
         state      <= IDLE;
         sdr_req    <= 1'b0;
         sdr_addr   <= '0;
         sdr_din    <= '0;
         sdr_be     <= 2'b00;
         pend       <= 1'b0;
         pend_waddr <= '0;
         pend_data  <= '0;
         skid_full  <= 1'b0;
         skid_waddr <= '0;
         skid_odd   <= 1'b0;
         skid_data  <= '0;
         overflow   <= 1'b0;
         dl_q       <= 1'b0;
         ending     <= 1'b0;
         done       <= 1'b0;
         wr_count   <= '0;
      end else begin
         done     <= 1'b0;
         dl_q     <= ioctl_download;
         overflow <= overflow | drop_c;

         if (load_skid_c) begin
            skid_full  <= 1'b1;
            skid_waddr <= live_waddr_c;
            skid_odd   <= ioctl_addr[0];
            skid_data  <= ioctl_dout;
         end else if (idle_c && skid_full && !mismatch_c) begin
            skid_full <= 1'b0;
         end

         if (dl_fall_c) ending <= 1'b1;

         case (state)
            IDLE: begin
               if (in_valid_c) begin
                  // A pending byte for another word is written alone before the new byte.
                  if (mismatch_c) begin
                     sdr_addr <= pend_waddr;
                     sdr_din  <= pack(pend_data, 8'h00);
                     sdr_be   <= 2'b01;
                     pend     <= 1'b0;
                     state    <= SETUP;
                  end else if (in_odd_c) begin
                     sdr_addr <= in_waddr_c;
                     sdr_din  <= pack(pend ? pend_data : 8'h00, in_data_c);
                     sdr_be   <= {1'b1, pend};
                     pend     <= 1'b0;
                     state    <= SETUP;
                  end else begin
                     pend       <= 1'b1;
                     pend_waddr <= in_waddr_c;
                     pend_data  <= in_data_c;
                  end
               end else if (ending) begin
                  if (pend) begin
                     sdr_addr <= pend_waddr;
                     sdr_din  <= pack(pend_data, 8'h00);
                     sdr_be   <= 2'b01;
                     pend     <= 1'b0;
                     state    <= SETUP;
                  end else begin
                     done   <= 1'b1;
                     ending <= 1'b0;
                  end
               end
            end
            SETUP: begin
               state   <= REQ;
               sdr_req <= 1'b1;
            end
            REQ: begin
               if (sdr_ready) begin
                  state    <= REL;
                  sdr_req  <= 1'b0;
                  wr_count <= wr_count + 26'd1;
               end
            end
            REL: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (dl_rise_c) begin
            wr_count <= '0;
            overflow <= 1'b0;
            ending   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: a byte-level reference model predicts SDRAM writes and done pulses.
module tb_rom_loader;
   localparam logic [26:0] BASE = 27'h100000;
   localparam bit          SWAP = 1'b1;

   logic        clk = 1'b0;
   logic        init, ioctl_download, ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [26:1] sdr_addr;
   logic [15:0] sdr_din;
   logic [1:0]  sdr_be;
   logic        sdr_rnw, sdr_req, sdr_ready, done;
   logic [25:0] wr_count;

   rom_loader #(.BASE_ADDR(BASE), .BYTE_SWAP(SWAP)) dut (
      .clk(clk), .init(init), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .sdr_addr(sdr_addr), .sdr_din(sdr_din), .sdr_be(sdr_be), .sdr_rnw(sdr_rnw),
      .sdr_req(sdr_req), .sdr_ready(sdr_ready), .done(done), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [25:0] addr;
      logic [15:0] din;
      logic [1:0]  be;
   } wr_t;

   wr_t         exp_q[$];
   int unsigned done_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          done_seen = 0;
   bit          auto_ack = 1'b1;
   bit          force_ready = 1'b0;
   bit          abort_ok = 1'b0;

   bit          m_pend = 1'b0;
   logic [25:0] m_paddr;
   logic [7:0]  m_pdata;
   int unsigned m_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one expected SDRAM write built from which bytes of the word are present.
   task automatic emit(input logic [25:0] a, input logic [7:0] ev, input logic [7:0] od,
                       input bit has_ev, input bit has_od);
      wr_t w;
      logic [7:0] e8, o8;
      e8 = has_ev ? ev : 8'h00;
      o8 = has_od ? od : 8'h00;
      w.addr = a;
      w.din  = SWAP ? {e8, o8} : {o8, e8};
      w.be   = {has_od, has_ev};
      exp_q.push_back(w);
      m_count++;
   endtask

   task automatic model_byte(input logic [26:0] a, input logic [7:0] d);
      logic [26:0] s;
      logic [25:0] w;
      s = a + BASE;
      w = s[26:1];
      if (m_pend && m_paddr != w) begin
         emit(m_paddr, m_pdata, 8'h00, 1'b1, 1'b0);
         m_pend = 1'b0;
      end
      if (a[0]) begin
         emit(w, m_pdata, d, m_pend, 1'b1);
         m_pend = 1'b0;
      end else begin
         m_pend  = 1'b1;
         m_paddr = w;
         m_pdata = d;
      end
   endtask

   task automatic strobe(input logic [26:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic send(input logic [26:0] a, input logic [7:0] d, input int gap);
      int n;
      n = 0;
      while (ioctl_wait && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_timeout", 64'(n < 200), 64'd1);
      model_byte(a, d);
      strobe(a, d);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      m_count = 0;
      @(posedge clk); #1;
   endtask

   task automatic end_dl();
      int n, target;
      ioctl_download = 1'b0;
      if (m_pend) begin
         emit(m_paddr, m_pdata, 8'h00, 1'b1, 1'b0);
         m_pend = 1'b0;
      end
      done_q.push_back(m_count);
      target = done_seen + 1;
      n = 0;
      while (done_seen < target && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_timeout", 64'(done_seen >= target), 64'd1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // SDRAM responder: random acknowledge latency, one-cycle sdr_ready.
   initial begin : responder
      int ack_delay;
      ack_delay = 0;
      sdr_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         sdr_ready = force_ready;
         if (auto_ack && sdr_req) begin
            if (ack_delay == 0) begin
               sdr_ready = 1'b1;
               ack_delay = $urandom_range(0, 4);
            end else begin
               ack_delay--;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each request rise and each done pulse.
   initial begin : monitor
      logic prev_req, prev_ready;
      wr_t  e;
      prev_req = 1'b0;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (sdr_req && !prev_req) begin
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sdr_addr", 64'(sdr_addr), 64'(e.addr));
               check("sdr_din", 64'(sdr_din), 64'(e.din));
               check("sdr_be", 64'(sdr_be), 64'(e.be));
            end
            check("sdr_rnw", 64'(sdr_rnw), 64'd0);
         end
         if (!sdr_req && prev_req && !abort_ok)
            check("req_held_until_ready", 64'(prev_ready), 64'd1);
         if (done) begin
            check("done_expected", 64'(done_q.size() > 0), 64'd1);
            check("writes_left_at_done", 64'(exp_q.size()), 64'd0);
            if (done_q.size() > 0) check("wr_count_at_done", 64'(wr_count), 64'(done_q.pop_front()));
            done_seen++;
         end
         prev_req = sdr_req;
         prev_ready = sdr_ready;
      end
   end

   initial begin : stimulus
      logic [26:0] a;
      logic [25:0] cnt_snap;
      int n;
      init = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
      repeat (3) @(posedge clk);
      #1 init = 1'b0;
      @(negedge clk);
      check("rst_sdr_req", 64'(sdr_req), 64'd0);
      check("rst_sdr_be", 64'(sdr_be), 64'd0);
      check("rst_sdr_addr", 64'(sdr_addr), 64'd0);
      check("rst_sdr_din", 64'(sdr_din), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wr_count", 64'(wr_count), 64'd0);
      check("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
      @(posedge clk); #1;

      // Full word pair.
      start_dl();
      send(27'h0, 8'h34, 0);
      send(27'h1, 8'h12, 0);
      end_dl();
      check("pair_addr", 64'(sdr_addr), 64'h080000);
      check("pair_din", 64'(sdr_din), 64'h3412);
      check("pair_be", 64'(sdr_be), 64'd3);

      // Three bytes: trailing even byte flushed on download fall.
      start_dl();
      send(27'h0, 8'hA0, 1);
      send(27'h1, 8'hA1, 0);
      send(27'h2, 8'hA2, 2);
      end_dl();
      check("flush_addr", 64'(sdr_addr), 64'h080001);
      check("flush_be", 64'(sdr_be), 64'd1);
      check("flush_count", 64'(wr_count), 64'd2);

      // Strobe in SETUP is skidded, strobe in REQ is dropped.
      start_dl();
      send(27'h11, 8'h5A, 0);
      model_byte(27'h21, 8'h6B);
      strobe(27'h21, 8'h6B);
      strobe(27'h31, 8'h7C);
      repeat (20) begin @(posedge clk); #1; end
      check("overflow_set", 64'(dut.overflow), 64'd1);
      end_dl();
      start_dl();
      check("overflow_cleared", 64'(dut.overflow), 64'd0);
      end_dl();

      // Random downloads with address jumps and top-of-space wrap.
      for (int d = 0; d < 6; d++) begin
         start_dl();
         a = ($urandom_range(0, 2) == 0) ? 27'h7FFFFF3 : 27'($urandom);
         n = $urandom_range(4, 30);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) a = 27'($urandom);
            send(a, 8'($urandom), $urandom_range(0, 2));
            a = a + 27'd1;
         end
         end_dl();
      end

      // Strobe with download low is ignored.
      cnt_snap = wr_count;
      strobe(27'h1, 8'hEE);
      repeat (10) begin @(posedge clk); #1; end
      check("ignored_wr_count", 64'(wr_count), 64'(cnt_snap));
      check("ignored_no_write", 64'(exp_q.size()), 64'd0);

      // init while in REQ abandons the write.
      start_dl();
      auto_ack = 1'b0;
      send(27'h41, 8'h99, 0);
      n = 0;
      while (!sdr_req && n < 50) begin @(posedge clk); #1; n++; end
      check("req_timeout", 64'(sdr_req), 64'd1);
      abort_ok = 1'b1;
      init = 1'b1; ioctl_download = 1'b0;
      @(posedge clk); #1;
      init = 1'b0;
      m_pend = 1'b0;
      @(negedge clk);
      check("abort_req_low", 64'(sdr_req), 64'd0);
      check("abort_wr_count", 64'(wr_count), 64'd0);
      @(posedge clk); #1;
      force_ready = 1'b1;
      @(posedge clk); #1;
      force_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("late_ready_wr_count", 64'(wr_count), 64'd0);
      check("late_ready_req", 64'(sdr_req), 64'd0);
      check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
